// File: rtl/pxs_grid_ctrl.sv
// pxs_grid_ctrl: frame-synchronous programmable grid overlay on the 26-bit pixel stream; optional crosshair via PXS_GRID_CROSSHAIR_EN
module pxs_grid_ctrl #(
  parameter int DEF_LOG2GS = 3,
  parameter int DEF_COLOR  = 0,
  parameter int DEF_EN     = 1,
  parameter int CX         = 320,
  parameter int CY         = 240
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] RGBStr_i,
  output logic [25:0] RGBStr_o,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_data,
  output logic        cfg_pending,
  output logic [7:0]  frame_cnt
);
  localparam int VS_B  = 24;
  localparam int ACT_B = 3;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t      state;
  logic        vs_q;
  logic [7:0]  shadow;
  logic        act_en, act_col;
  logic [2:0]  act_lg, act_bl;
  logic        fs, commit;
  logic        u_en, u_col;
  logic [2:0]  u_lg, u_bl;
  logic [7:0]  cnt_use;
  logic [9:0]  x, y, mask;
  logic        hit, vis;
  logic [2:0]  rgb_new;
  if (CX < 0 || CX > 1023 || CY < 0 || CY > 1023) begin : g_bad_xy
    $error("CX/CY must fit the 10-bit coordinate range");
  end
  // Effective settings for the current pixel: a commit at frame start already applies to the fs pixel
  always_comb begin
    fs      = RGBStr_i[VS_B] & ~vs_q;
    commit  = (state == PENDING) & fs;
    u_en    = commit ? shadow[0] : act_en;
    u_lg    = commit ? ((shadow[3:1] == 3'd0) ? 3'd1 : shadow[3:1]) : act_lg;
    u_col   = commit ? shadow[4] : act_col;
    u_bl    = commit ? shadow[7:5] : act_bl;
    cnt_use = frame_cnt + {7'd0, fs};
    x       = RGBStr_i[23:14];
    y       = RGBStr_i[13:4];
    mask    = ~(10'h3FF << u_lg);
    hit     = u_en & RGBStr_i[ACT_B] & (((x & mask) == 10'd0) | ((y & mask) == 10'd0));
    vis     = (u_bl == 3'd0) | ~cnt_use[u_bl - 3'd1];
`ifdef PXS_GRID_CROSSHAIR_EN
    rgb_new = (u_en & RGBStr_i[ACT_B] & ((x == 10'(CX)) | (y == 10'(CY)))) ? {3{~u_col}} :
              (hit & vis) ? {3{u_col}} : RGBStr_i[2:0];
`else
    rgb_new = (hit & vis) ? {3{u_col}} : RGBStr_i[2:0];
`endif
  end
  // One-cycle registered stream; only the RGB field is overlaid
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) RGBStr_o <= '0;
    else RGBStr_o <= {RGBStr_i[25:3], rgb_new};
  // Frame-start edge history (reset high so a VS already asserted at release is not a frame start) and frame counter
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_q <= RGBStr_i[VS_B];
      if (fs) frame_cnt <= frame_cnt + 8'd1;
    end
  // Config handshake: latch into shadow when idle, commit shadow to active at the next frame start
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
      shadow      <= '0;
      act_en      <= DEF_EN[0];
      act_lg      <= DEF_LOG2GS[2:0];
      act_col     <= DEF_COLOR[0];
      act_bl      <= 3'd0;
    end else if (state == IDLE) begin
      if (cfg_valid) begin
        shadow      <= cfg_data;
        state       <= PENDING;
        cfg_ready   <= 1'b0;
        cfg_pending <= 1'b1;
      end
    end else if (fs) begin
      act_en      <= u_en;
      act_lg      <= u_lg;
      act_col     <= u_col;
      act_bl      <= u_bl;
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
    end
endmodule

// File: tb/tb_pxs_grid_ctrl.sv
// tb_pxs_grid_ctrl: randomized stream checked against a frame-level reference model of the grid overlay
module tb_pxs_grid_ctrl;
  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [25:0] RGBStr_i;
  logic [25:0] RGBStr_o;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic        cfg_pending;
  logic [7:0]  frame_cnt;
  int          ncmp = 0;
  int          nerr = 0;
  bit          m_vsp, m_en, m_col, m_pend;
  int          m_lg, m_bl;
  logic [7:0]  m_sh, m_cnt;
  logic [25:0] exp_o;

  pxs_grid_ctrl dut (
    .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_pending(cfg_pending), .frame_cnt(frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  task automatic model_reset();
    m_vsp = 1'b1; m_en = 1'b1; m_col = 1'b0; m_lg = 3; m_bl = 0;
    m_pend = 1'b0; m_sh = '0; m_cnt = '0;
  endtask

  // Present one pixel, predict its output from the model, advance past the clock edge
  task automatic step(input logic hs, input logic vs, input logic [9:0] x, input logic [9:0] y,
                      input logic act, input logic [2:0] rgb, input logic cv, input logic [7:0] cd);
    bit fs, pend0, hit, vis;
    int pitch;
    logic [7:0] ce;
    logic [2:0] ro;
    RGBStr_i = {hs, vs, x, y, act, rgb}; cfg_valid = cv; cfg_data = cd;
    fs = vs && !m_vsp;
    pend0 = m_pend;
    if (fs && m_pend) begin
      m_en = m_sh[0]; m_lg = (m_sh[3:1] == 0) ? 1 : int'(m_sh[3:1]);
      m_col = m_sh[4]; m_bl = int'(m_sh[7:5]); m_pend = 1'b0;
    end
    ce = fs ? m_cnt + 8'd1 : m_cnt;
    pitch = 1 << m_lg;
    hit = m_en && act && (int'(x) % pitch == 0 || int'(y) % pitch == 0);
    vis = (m_bl == 0) || ((int'(ce) / (1 << (m_bl - 1))) % 2 == 0);
    ro = (hit && vis) ? {3{m_col}} : rgb;
`ifdef PXS_GRID_CROSSHAIR_EN
    if (m_en && act && (x == 10'd320 || y == 10'd240)) ro = {3{~m_col}};
`endif
    exp_o = {hs, vs, x, y, act, ro};
    if (!pend0 && cv) begin m_sh = cd; m_pend = 1'b1; end
    if (fs) m_cnt = m_cnt + 8'd1;
    m_vsp = vs;
    @(posedge px_clk); #1;
  endtask

  task automatic rstep(input logic vs, input logic cv, input logic [7:0] cd);
    logic [9:0] x, y;
    x = 10'($urandom_range(0, 639));
    y = 10'($urandom_range(0, 479));
    if ($urandom_range(0, 2) == 0) x = x & 10'h3F0;
    if ($urandom_range(0, 3) == 0) y = y & 10'h3F0;
    step(1'($urandom), vs, x, y, $urandom_range(0, 4) != 0, 3'($urandom), cv, cd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RGBStr_i = '0; cfg_valid = 1'b0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge px_clk);
    #1;
    ncmp++; if (RGBStr_o !== 26'd0) begin nerr++; $display("FAIL reset_out: got %h want 0", RGBStr_o); end
    ncmp++; if (cfg_ready !== 1'b1 || cfg_pending !== 1'b0 || frame_cnt !== 8'd0) begin
      nerr++; $display("FAIL reset_status: got rdy=%b pend=%b cnt=%0d want 1 0 0", cfg_ready, cfg_pending, frame_cnt); end
    @(negedge px_clk); rst_n = 1'b1;
    step(0, 1, 10'd5, 10'd5, 0, 3'b101, 0, 0);
    ncmp++; if (frame_cnt !== 8'd0) begin nerr++; $display("FAIL vs_high_at_release: got cnt=%0d want 0", frame_cnt); end
    step(0, 0, 10'd0, 10'd0, 1, 3'b101, 0, 0);
    ncmp++; if (RGBStr_o[2:0] !== 3'b000) begin nerr++; $display("FAIL def_origin: got %b want 000", RGBStr_o[2:0]); end
    step(1, 0, 10'd3, 10'd5, 1, 3'b101, 0, 0);
    ncmp++; if (RGBStr_o !== {1'b1, 1'b0, 10'd3, 10'd5, 1'b1, 3'b101}) begin
      nerr++; $display("FAIL def_x3y5: got %h want %h", RGBStr_o, {1'b1, 1'b0, 10'd3, 10'd5, 1'b1, 3'b101}); end
    step(0, 0, 10'd8, 10'd5, 1, 3'b101, 0, 0);
    ncmp++; if (RGBStr_o[2:0] !== 3'b000) begin nerr++; $display("FAIL def_x8: got %b want 000", RGBStr_o[2:0]); end
    step(0, 0, 10'd3, 10'd16, 1, 3'b101, 0, 0);
    ncmp++; if (RGBStr_o[2:0] !== 3'b000) begin nerr++; $display("FAIL def_y16: got %b want 000", RGBStr_o[2:0]); end
  endtask

  task automatic test_defaults();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 60; i++) begin
        rstep(i < 2, 0, 0);
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL defaults f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
      end
    ncmp++; if (frame_cnt !== m_cnt) begin nerr++; $display("FAIL defaults_cnt: got %0d want %0d", frame_cnt, m_cnt); end
  endtask

  task automatic test_deferred();
    for (int i = 0; i < 40; i++) begin
      if (i == 10) step(0, 0, 10'd8, 10'd3, 1, 3'b010, 1, 8'h19);
      else rstep(i < 2, i > 10 ? 1'($urandom) : 1'b0, 8'($urandom));
      ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL deferred_old p%0d: got %h want %h", i, RGBStr_o, exp_o); end
      if (i == 10) begin
        ncmp++; if (cfg_ready !== 1'b0 || cfg_pending !== 1'b1) begin
          nerr++; $display("FAIL deferred_hs: got rdy=%b pend=%b want 0 1", cfg_ready, cfg_pending); end
        ncmp++; if (RGBStr_o[2:0] !== 3'b000) begin nerr++; $display("FAIL deferred_still8: got %b want 000", RGBStr_o[2:0]); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 2) step(0, 0, 10'd8, 10'd3, 1, 3'b010, 0, 0);
      else if (i == 3) step(0, 0, 10'd32, 10'd3, 1, 3'b010, 0, 0);
      else rstep(i < 2, 0, 0);
      ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL deferred_new p%0d: got %h want %h", i, RGBStr_o, exp_o); end
      if (i == 0) begin
        ncmp++; if (cfg_ready !== 1'b1 || cfg_pending !== 1'b0) begin
          nerr++; $display("FAIL deferred_commit: got rdy=%b pend=%b want 1 0", cfg_ready, cfg_pending); end
      end
      if (i == 2) begin ncmp++; if (RGBStr_o[2:0] !== 3'b010) begin nerr++; $display("FAIL deferred_x8: got %b want 010", RGBStr_o[2:0]); end end
      if (i == 3) begin ncmp++; if (RGBStr_o[2:0] !== 3'b111) begin nerr++; $display("FAIL deferred_x32: got %b want 111", RGBStr_o[2:0]); end end
    end
  endtask

  task automatic test_accept_on_fs();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 30; i++) begin
        if (i == 3) step(0, 0, 10'd16, 10'd1, 1, 3'b010, 0, 0);
        else rstep(i < 2, f == 0 && i == 0, 8'h00);
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL fs_accept f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
        if (i == 3) begin
          ncmp++; if (RGBStr_o[2:0] !== (f == 0 ? 3'b111 : 3'b010)) begin
            nerr++; $display("FAIL fs_accept_grid f%0d: got %b want %b", f, RGBStr_o[2:0], f == 0 ? 3'b111 : 3'b010); end
        end
      end
  endtask

  task automatic test_blink();
    bit wrapped = 0;
    for (int i = 0; i < 10; i++) rstep(i < 2, i == 5, 8'h23);
    for (int f = 0; f < 300; f++)
      for (int i = 0; i < 8; i++) begin
        if (i == 3) step(0, 0, 10'd0, 10'd0, 1, 3'b010, 0, 0);
        else rstep(i < 2, 0, 0);
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL blink f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
        if (i == 3) begin
          ncmp++; if (RGBStr_o[2:0] !== (m_cnt[0] ? 3'b010 : 3'b000) || frame_cnt !== m_cnt) begin
            nerr++; $display("FAIL blink_vis f%0d: got rgb=%b cnt=%0d want rgb=%b cnt=%0d", f, RGBStr_o[2:0], frame_cnt, m_cnt[0] ? 3'b010 : 3'b000, m_cnt); end
          if (m_cnt == 8'd0) wrapped = 1;
        end
      end
    ncmp++; if (!wrapped || frame_cnt !== m_cnt) begin nerr++; $display("FAIL blink_wrap: got cnt=%0d want %0d wrapped=%0d", frame_cnt, m_cnt, wrapped); end
  endtask

  task automatic test_clamp();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 40; i++) begin
        if (f == 1 && i == 2) step(0, 0, 10'd2, 10'd1, 1, 3'b000, 0, 0);
        else if (f == 1 && i == 3) step(0, 0, 10'd1, 10'd1, 1, 3'b000, 0, 0);
        else if (f == 1 && i == 4) step(0, 0, 10'd0, 10'd0, 0, 3'b010, 0, 0);
        else rstep(i < 2, f == 0 && i == 5, 8'h11);
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL clamp f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
        if (f == 1 && i == 2) begin ncmp++; if (RGBStr_o[2:0] !== 3'b111) begin nerr++; $display("FAIL clamp_x2: got %b want 111", RGBStr_o[2:0]); end end
        if (f == 1 && i == 3) begin ncmp++; if (RGBStr_o[2:0] !== 3'b000) begin nerr++; $display("FAIL clamp_x1: got %b want 000", RGBStr_o[2:0]); end end
        if (f == 1 && i == 4) begin ncmp++; if (RGBStr_o[2:0] !== 3'b010) begin nerr++; $display("FAIL blank_x0: got %b want 010", RGBStr_o[2:0]); end end
      end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 30; i++) begin
        rstep(i < 2, 1'b1, 8'($urandom));
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL b2b f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
        ncmp++; if (cfg_ready !== !m_pend || cfg_pending !== m_pend || frame_cnt !== m_cnt) begin
          nerr++; $display("FAIL b2b_status f%0d p%0d: got rdy=%b pend=%b cnt=%0d want %b %b %0d", f, i, cfg_ready, cfg_pending, frame_cnt, !m_pend, m_pend, m_cnt); end
      end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) rstep(i < 2, i == 6, 8'h19);
    ncmp++; if (cfg_pending !== 1'b1) begin nerr++; $display("FAIL mid_pending: got %b want 1", cfg_pending); end
    #2 rst_n = 1'b0;
    #1;
    ncmp++; if (RGBStr_o !== 26'd0 || cfg_pending !== 1'b0 || cfg_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      nerr++; $display("FAIL mid_async: got out=%h pend=%b rdy=%b cnt=%0d want 0 0 1 0", RGBStr_o, cfg_pending, cfg_ready, frame_cnt); end
    model_reset();
    repeat (2) @(posedge px_clk);
    @(negedge px_clk); rst_n = 1'b1;
    step(0, 0, 10'd8, 10'd3, 1, 3'b111, 0, 0);
    ncmp++; if (RGBStr_o[2:0] !== 3'b000 || cfg_pending !== 1'b0) begin
      nerr++; $display("FAIL mid_defaults: got rgb=%b pend=%b want 000 0", RGBStr_o[2:0], cfg_pending); end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 30; i++) begin
        rstep(i < 2, 0, 0);
        ncmp++; if (RGBStr_o !== exp_o) begin nerr++; $display("FAIL mid_after f%0d p%0d: got %h want %h", f, i, RGBStr_o, exp_o); end
      end
`ifdef PXS_GRID_CROSSHAIR_EN
    step(0, 0, 10'd320, 10'd3, 1, 3'b010, 0, 0);
    ncmp++; if (RGBStr_o[2:0] !== 3'b111) begin nerr++; $display("FAIL crosshair_x320: got %b want 111", RGBStr_o[2:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_deferred();
    test_accept_on_fs();
    test_blink();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
